// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  localparam int DataBits          = 8;
  localparam int DefaultOversample = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Multi-flop synchronizer for the asynchronous serial line; idles high out of reset.
module Synchronizer #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SyncStages-1:0] sync_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits, optional parity, one stop bit,
// valid/ready output handshake with sticky overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Oversample = DefaultOversample,
  parameter int SyncStages = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                syncReset,
  input  logic                rxTick,
  input  logic                rx,
  input  logic                parityEn,
  input  logic                parityOdd,
  output logic [DataBits-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                frameError,
  output logic                parityError,
  output logic                overrun
);

  localparam int CntW = $clog2(Oversample);
  localparam int IdxW = $clog2(DataBits);
  localparam logic [CntW-1:0] CntHalf = CntW'(Oversample / 2 - 2);
  localparam logic [CntW-1:0] CntLast = CntW'(Oversample - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);

  logic [1:0]          rst_pipe_q;
  logic                rst_int;
  logic                rxs;
  rx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                armed_q, armed_d;
  logic                par_en_q, par_en_d;
  logic                par_odd_q, par_odd_d;
  logic                par_bit_q, par_bit_d;
  logic                done;
  logic [DataBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                parity_err_q, parity_err_d;
  logic                overrun_q, overrun_d;

  // Reset takes effect at once but is released only on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe_q <= 2'b11;
    else       rst_pipe_q <= {rst_pipe_q[0], 1'b0};
  end
  assign rst_int = rst_pipe_q[1];

  Synchronizer #(.SyncStages(SyncStages)) u_sync (
    .clk  (clk),
    .reset(rst_int),
    .d_i  (rx),
    .q_o  (rxs)
  );

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    par_bit_d = par_bit_q;
    done      = 1'b0;
    if (rxTick) begin
      case (state_q)
        RX_IDLE: begin
          if (rxs) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d   = RX_START;
            cnt_d     = '0;
            par_en_d  = parityEn;
            par_odd_d = parityOdd;
          end
        end
        RX_START: begin
          if (cnt_q == CntHalf) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            shift_d[idx_q] = rxs;
            if (idx_q == IdxLast) state_d = par_en_q ? RX_PARITY : RX_STOP;
            else                  idx_d   = idx_q + 1'b1;
          end
        end
        RX_PARITY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            par_bit_d = rxs;
            state_d   = RX_STOP;
          end
        end
        RX_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            done    = 1'b1;
            armed_d = 1'b0;
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int || syncReset) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      par_bit_q <= par_bit_d;
    end
  end

  // A completed byte is only dropped when the held one has not been taken this cycle.
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    if (done) begin
      if (!valid_q || ready) begin
        data_d       = shift_q;
        frame_err_d  = ~rxs;
        parity_err_d = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int || syncReset) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frameError  = frame_err_q;
  assign parityError = parity_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; received bytes are checked against a scoreboard queue.
module tb_uart_rx;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       syncReset = 1'b0;
  logic       rxTick = 1'b0;
  logic       rx = 1'b1;
  logic       parityEn = 1'b0;
  logic       parityOdd = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b1;
  logic       frameError;
  logic       parityError;
  logic       overrun;

  int   total = 0;
  int   bad = 0;
  int   acc_count = 0;
  int   tick_div = 1;
  int   tick_ph = 0;
  logic acc_prev = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;

  uart_rx #(.Oversample(OS), .SyncStages(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .syncReset  (syncReset),
    .rxTick     (rxTick),
    .rx         (rx),
    .parityEn   (parityEn),
    .parityOdd  (parityOdd),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frameError (frameError),
    .parityError(parityError),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
    rxTick  = (tick_ph == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest expectation,
  // and valid must drop the cycle after an acceptance.
  always @(negedge clk) begin
    if (acc_prev) check("valid_one_cycle", 32'(valid), 32'd0);
    acc_prev = valid && ready && !reset;
    if (valid && ready) begin
      acc_count++;
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("sb_data", 32'(data), 32'(mon_e.d));
        check("sb_frame_err", 32'(frameError), 32'(mon_e.fe));
        check("sb_parity_err", 32'(parityError), 32'(mon_e.pe));
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (rxTick) k++;
    end
    #2;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pen, input logic pbit,
                            input logic stop_bit, input logic idle_after);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (pen) send_bit(pbit);
    send_bit(stop_bit);
    if (idle_after) send_bit(1'b1);
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_fe"}, 32'(frameError), 32'd0);
    check({tag, "_pe"}, 32'(parityError), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int c0;

    // Reset state
    @(negedge clk);
    check_outputs_clear("reset");
    @(posedge clk); #2;
    reset = 1'b0;
    wait_ticks(20);

    // 0xA5, 8N1, one-cycle valid with ready held high
    c0 = acc_count;
    sb_q.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    check("a5_accepted", 32'(acc_count), 32'(c0 + 1));
    check("a5_data_held", 32'(data), 32'hA5);

    // Short start-bit glitch produces nothing
    c0 = acc_count;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_no_accept", 32'(acc_count), 32'(c0));

    // 0x3C with a low stop bit; line then stays low and must not restart
    c0 = acc_count;
    sb_q.push_back('{d: 8'h3C, fe: 1'b1, pe: 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ticks(200);
    check("fe_single_accept", 32'(acc_count), 32'(c0 + 1));
    rx = 1'b1;
    wait_ticks(32);

    // Sparse rxTick: one tick every third cycle
    tick_div = 3;
    wait_ticks(4);
    c0 = acc_count;
    sb_q.push_back('{d: 8'h5A, fe: 1'b0, pe: 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    check("slow_tick_accept", 32'(acc_count), 32'(c0 + 1));
    tick_div = 1;
    wait_ticks(4);

    // Even parity on 0x03: parity bit 0 is correct, 1 is an error
    parityEn  = 1'b1;
    parityOdd = 1'b0;
    sb_q.push_back('{d: 8'h03, fe: 1'b0, pe: 1'b0});
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
    sb_q.push_back('{d: 8'h03, fe: 1'b0, pe: 1'b1});
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    check("parity_err_held", 32'(parityError), 32'd1);

    // Odd parity on 0x07 with parity bit 0; config flips mid-frame and must be ignored
    parityOdd = 1'b1;
    sb_q.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
    fork
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
      begin
        wait_ticks(40);
        parityOdd = 1'b0;
        parityEn  = 1'b0;
      end
    join
    check("odd_data_held", 32'(data), 32'h07);

    // Reset in the middle of 0x55, then 0x96
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_ticks(5);
    reset = 1'b1;
    #1;
    check_outputs_clear("async_reset");
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    wait_ticks(20);
    c0 = acc_count;
    sb_q.push_back('{d: 8'h96, fe: 1'b0, pe: 1'b0});
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_reset_accept", 32'(acc_count), 32'(c0 + 1));

    // Overrun: 0x11 then 0x22 with ready low
    ready = 1'b0;
    sb_q.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_data", 32'(data), 32'h11);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_cleared", 32'(valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    @(posedge clk); #2;
    syncReset = 1'b1;
    @(posedge clk); #2;
    syncReset = 1'b0;
    check("sync_reset_ovr", 32'(overrun), 32'd0);
    check("sync_reset_data", 32'(data), 32'd0);

    // A frame still works after the synchronous clear
    wait_ticks(8);
    sb_q.push_back('{d: 8'hC3, fe: 1'b0, pe: 1'b0});
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
